// File: rtl/hc_stream_arbiter.sv
// hc_stream_arbiter
// Shares the Xillybus host-to-card (hcw) and card-to-host (hcr) streams
// between four compute cores on bus_clk.
//  - Write side: a header word picks the destination core ([31:30]) and the
//    payload length ([7:0]). The header itself is consumed and never
//    forwarded. The payload goes to that core's input FIFO with no added
//    latency.
//  - Read side: whole packets from the core output FIFOs are merged
//    round-robin. The source core ID is stamped into header bits [31:30].
// Ports:
//  bus_clk, reset (async, active-high)
//  user_w_hcw_*  : host write stream (wren/data/open in, full out)
//  core_in_*     : per-core input FIFO write enables, shared data, full flags
//  user_r_hcr_*  : host read stream (rden/open in, data/empty/eof out)
//  core_out_*    : per-core output FIFO read enables, flattened data, empty flags
//  wr_abort      : one-cycle pulse when hcw closes mid-packet
//
// state  | meaning
// W_HDR  | waiting for a header word on hcw
// W_PAY  | forwarding payload words to core_in[dest]
// R_ARB  | round-robin search for a core with pending output
// R_HDR  | reading the header word of the granted core
// R_LEN  | header valid on the bus: stamp the ID, load the length
// R_PKT  | streaming payload words from the granted core
module hc_stream_arbiter #(
  parameter int NCORES = 4,
  parameter int DW     = 32
) (
  input  logic                 bus_clk,
  input  logic                 reset,
  input  logic                 user_w_hcw_wren,
  input  logic [DW-1:0]        user_w_hcw_data,
  input  logic                 user_w_hcw_open,
  output logic                 user_w_hcw_full,
  output logic [NCORES-1:0]    core_in_wren,
  output logic [DW-1:0]        core_in_data,
  input  logic [NCORES-1:0]    core_in_full,
  input  logic                 user_r_hcr_rden,
  input  logic                 user_r_hcr_open,
  output logic [DW-1:0]        user_r_hcr_data,
  output logic                 user_r_hcr_empty,
  output logic                 user_r_hcr_eof,
  output logic [NCORES-1:0]    core_out_rden,
  input  logic [NCORES*DW-1:0] core_out_data,
  input  logic [NCORES-1:0]    core_out_empty,
  output logic                 wr_abort
);

  typedef enum logic {W_HDR, W_PAY} w_state_t;
  typedef enum logic [1:0] {R_ARB, R_HDR, R_LEN, R_PKT} r_state_t;

  w_state_t   w_state, w_next;
  logic [1:0] dest, dest_next;
  logic [7:0] cnt, cnt_next;

  r_state_t   r_state, r_next;
  logic [1:0] grant, grant_next;
  logic [7:0] rem, rem_next;

  logic [DW-1:0] out_word;
  logic          rd_ok;
  logic          found;
  logic [1:0]    pick;

  // ---------------- write path ----------------
  always_ff @(posedge bus_clk or posedge reset) begin
    if (reset) begin
      w_state <= W_HDR;
      dest    <= '0;
      cnt     <= '0;
    end else begin
      w_state <= w_next;
      dest    <= dest_next;
      cnt     <= cnt_next;
    end
  end

  always_comb begin
    w_next    = w_state;
    dest_next = dest;
    cnt_next  = cnt;
    case (w_state)
      W_HDR: begin
        if (user_w_hcw_wren) begin
          dest_next = user_w_hcw_data[31:30];
          cnt_next  = user_w_hcw_data[7:0];
          w_next    = (user_w_hcw_data[7:0] != 8'd0) ? W_PAY : W_HDR;
        end
      end
      default: begin
        if (user_w_hcw_wren) cnt_next = cnt - 8'd1;
        // A final word arriving together with the close still completes the packet.
        if (user_w_hcw_wren && cnt == 8'd1) begin
          w_next = W_HDR;
        end else if (!user_w_hcw_open) begin
          w_next   = W_HDR;
          cnt_next = 8'd0;
        end
      end
    endcase
  end

  always_comb begin
    user_w_hcw_full = 1'b0;
    core_in_wren    = '0;
    wr_abort        = 1'b0;
    if (w_state == W_PAY) begin
      user_w_hcw_full    = core_in_full[dest];
      core_in_wren[dest] = user_w_hcw_wren;
      wr_abort           = !user_w_hcw_open && !(user_w_hcw_wren && cnt == 8'd1);
    end
  end

  assign core_in_data = user_w_hcw_data;

  // ---------------- read path ----------------
  always_ff @(posedge bus_clk or posedge reset) begin
    if (reset) begin
      r_state <= R_ARB;
      grant   <= 2'd3;
      rem     <= '0;
    end else begin
      r_state <= r_next;
      grant   <= grant_next;
      rem     <= rem_next;
    end
  end

  // Round-robin search starting just after the current grant; i = 4 wraps
  // back to the current grant, so it has the lowest priority.
  always_comb begin
    found = 1'b0;
    pick  = grant;
    for (int i = 1; i <= NCORES; i++) begin
      if (!found && !core_out_empty[grant + 2'(i)]) begin
        found = 1'b1;
        pick  = grant + 2'(i);
      end
    end
  end

  assign out_word = core_out_data[{grant, 5'd0} +: DW];

  always_comb begin
    r_next     = r_state;
    grant_next = grant;
    rem_next   = rem;
    // A closed stream freezes the FSM so a packet resumes on reopen.
    if (user_r_hcr_open) begin
      case (r_state)
        R_ARB: begin
          if (found) begin
            grant_next = pick;
            r_next     = R_HDR;
          end
        end
        R_HDR: if (rd_ok) r_next = R_LEN;
        R_LEN: begin
          rem_next = out_word[7:0];
          r_next   = (out_word[7:0] == 8'd0) ? R_ARB : R_PKT;
        end
        default: begin
          if (rd_ok) begin
            rem_next = rem - 8'd1;
            if (rem == 8'd1) r_next = R_ARB;
          end
        end
      endcase
    end
  end

  always_comb begin
    user_r_hcr_empty = 1'b1;
    core_out_rden    = '0;
    user_r_hcr_data  = out_word;
    user_r_hcr_eof   = 1'b0;
    if (user_r_hcr_open && (r_state == R_HDR || r_state == R_PKT))
      user_r_hcr_empty = core_out_empty[grant];
    // A read while empty is a host protocol violation and is dropped here.
    rd_ok = user_r_hcr_rden && !user_r_hcr_empty;
    if (rd_ok) core_out_rden[grant] = 1'b1;
    if (r_state == R_LEN) user_r_hcr_data = {grant, out_word[29:0]};
  end

endmodule

// File: doc/hc_stream_arbiter.md
# hc_stream_arbiter

Shares the single host-to-card stream (hcw) and card-to-host stream (hcr) of the Xillybus core between four compute cores. Host-to-card packets are steered to one core's input FIFO by a header word. Card-to-host packets from the four cores' output FIFOs are merged round-robin, one whole packet at a time, with the source core ID stamped into each header. The block sits between the Xillybus user ports and the per-core FIFOs, all on `bus_clk`.

## Interface
- `NCORES`, 4: number of cores; fixed at 4, since header ID fields are 2 bits.
- `DW`, 32: stream word width.
- `bus_clk` in 1: single clock, the Xillybus user clock.
- `reset` in 1: asynchronous, active-high.
- `user_w_hcw_wren` in 1, `user_w_hcw_data` in 32, `user_w_hcw_open` in 1: host write stream.
- `user_w_hcw_full` out 1: backpressure to Xillybus.
- `core_in_wren` out 4: write enables to the core input FIFOs.
- `core_in_data` out 32: shared input data, equal to `user_w_hcw_data`.
- `core_in_full` in 4: core input FIFO full flags.
- `user_r_hcr_rden` in 1, `user_r_hcr_open` in 1: host read stream.
- `user_r_hcr_data` out 32, `user_r_hcr_empty` out 1, `user_r_hcr_eof` out 1: read stream outputs.
- `core_out_rden` out 4: read enables to the core output FIFOs, which are standard FIFOs with data valid the cycle after rden.
- `core_out_data` in 4x32: flattened; core k occupies [32k+31:32k].
- `core_out_empty` in 4: core output FIFO empty flags.
- `wr_abort` out 1: one-cycle pulse when the hcw stream closes mid-packet.

## Operation
**Header format (both directions):** [31:30] = core ID, [7:0] = payload length N (0..255 words). All other bits pass through unchanged.

**Write FSM (W_HDR, W_PAY):**
- W_HDR:
  - `user_w_hcw_full` = 0.
  - On wren: latch dest = data[31:30] and cnt = data[7:0].
  - Next state is W_PAY if N≠0; stay in W_HDR if N=0.
  - The header word is consumed and never forwarded.
- W_PAY:
  - `user_w_hcw_full` = `core_in_full[dest]`.
  - `core_in_wren[dest]` = `user_w_hcw_wren`, combinational. Other bits are 0.
  - Each wren decrements cnt. A wren with cnt==1 returns the FSM to W_HDR.
- `user_w_hcw_open`=0 in W_PAY: go to W_HDR, clear cnt, pulse `wr_abort`.

**Read FSM (R_ARB, R_HDR, R_LEN, R_PKT):** `grant` is 2 bits.
- R_ARB:
  - empty = 1.
  - Round-robin search from grant+1 (mod 4) for the first core with `core_out_empty`=0.
  - If one is found: load grant and go to R_HDR. Otherwise stay.
- R_HDR:
  - empty = `core_out_empty[grant]`.
  - rden is passed to `core_out_rden[grant]`.
  - On rden: go to R_LEN.
- R_LEN:
  - empty = 1.
  - Header data is valid this cycle. Load rem = `core_out_data[grant]`[7:0].
  - If rem=0 go to R_ARB, else go to R_PKT.
- R_PKT:
  - empty = `core_out_empty[grant]`.
  - rden is passed through to the granted core; each rden decrements rem.
  - rden with rem==1 goes to R_ARB.
- `user_r_hcr_data`:
  - Always `core_out_data[grant]`, a combinational mux.
  - In R_LEN, bits [31:30] are replaced by grant.
- `user_r_hcr_open`=0:
  - empty forced to 1 and `core_out_rden` = 0.
  - FSM state is held, so the packet resumes on reopen.
- `user_r_hcr_eof` is tied to 0.

## Timing
- **Reset values:** W_HDR, R_ARB, grant=3 (so core 0 is searched first), cnt=rem=0. `wr_abort`=0, `core_in_wren`=0, `core_out_rden`=0. `user_w_hcw_full`=0, `user_r_hcr_empty`=1.
- **Write path:**
  - Zero latency: full, wren and data are combinational in W_PAY.
  - Header acceptance is 1 cycle.
- **Read path:**
  - Data is valid the cycle after rden, matching Xillybus FIFO semantics.
  - Per-packet overhead is 2 bubble cycles, R_ARB and R_LEN.
  - grant changes only when leaving R_ARB. The last payload word, valid in the R_ARB cycle, therefore still uses the old grant.
- **Atomicity:** packets from different cores never interleave. A core with a partial packet stalls the read stream by holding empty=1 until its data arrives.
- **Simultaneous events:**
  - rden while empty=1 is ignored; a Xillybus protocol violation is not forwarded to any core.
  - A wren with cnt==1 and a simultaneous open drop counts as completed: no abort pulse.
- **Reset mid-packet:** both FSMs return to their reset states immediately (asynchronous); partial packets are discarded.

## Test plan
- **Write steering:** header 0x8000_0003, then 3 words A,B,C → only `core_in_wren[2]` pulses 3 times with A,B,C; header never appears; FSM back in W_HDR.
- **Write backpressure/abort:** header 0x4000_0004, `core_in_full[1]`=1 → `user_w_hcw_full`=1 and no wren. Release full, write 2 words, drop open → `wr_abort` pulses once; next word is treated as a header.
- **Zero-length packets:**
  - Write header 0xC000_0000 → no core write; FSM remains in W_HDR.
  - Core 3 output header 0x0000_0000 → host reads 0xC000_0000, FSM returns to R_ARB.
- **Round-robin read:**
  - Cores 0, 1 and 3 each hold a 2-word packet: header 0x0000_0002, then D0,D1.
  - Host reads in order: 0x0000_0002,D0,D1; 0x4000_0002,…; 0xC000_0002,… (cores 0, 1, 3).
  - Exactly 2 bubble cycles between packets.
- **Atomicity under starvation:** core 0 header says N=4 but only 2 payload words are present; core 1 is full → empty stays 1 after word 2 and core 1 is not granted until core 0's remaining 2 words arrive and are read.
- **Async reset mid-packet:** assert reset during R_PKT with rem=5 → outputs take reset values in the same cycle; after release the first grant goes to core 0.
